// File: rtl/vdp_port_if.sv
// CPU-side bus of the VDP I/O front end.
// Strobes, port select and write data toward the VDP; read data and busy back.
interface vdp_port_if;
    logic       cpu_wr;
    logic       cpu_rd;
    logic       cpu_port;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       busy;

    modport master (
        output cpu_wr, cpu_rd, cpu_port, cpu_din,
        input  cpu_dout, busy
    );

    modport slave (
        input  cpu_wr, cpu_rd, cpu_port, cpu_din,
        output cpu_dout, busy
    );
endinterface

// File: rtl/vdp_port.sv
// vdp_port: Z80 data/control port decode, VRAM pointer, read buffer,
// write-only mode registers R0-R7, status register and display decode.
// Ports: clk, reset (sync, active-high); bus (vdp_port_if.slave: cpu_wr,
// cpu_rd, cpu_port, cpu_din, cpu_dout, busy); vram_* to the VRAM CPU port;
// frame_int and sprite status in; mode/colour/table addresses and n_int out.
// Option: define VDP_RDBUF_ON_WRITE_EN to load the read buffer on data writes.
module vdp_port (
    input  logic        clk,
    input  logic        reset,
    vdp_port_if.slave   bus,
    output logic [13:0] vram_addr,
    output logic        vram_we,
    output logic        vram_re,
    output logic [7:0]  vram_din,
    input  logic [7:0]  vram_dout,
    input  logic        frame_int,
    input  logic        sprite_collision,
    input  logic        too_many_sprites,
    input  logic [4:0]  sprite5,
    output logic [1:0]  mode,
    output logic        video_on,
    output logic        vert_retrace_int,
    output logic        sprite_large,
    output logic        sprite_enlarged,
    output logic [3:0]  text_color,
    output logic [3:0]  back_color,
    output logic [13:0] name_table_addr,
    output logic [13:0] color_table_addr,
    output logic [13:0] font_addr,
    output logic [13:0] sprite_attr_addr,
    output logic [13:0] sprite_pattern_table_addr,
    output logic        n_int
);
    typedef enum logic [1:0] {
        S_IDLE, S_WR, S_RD_ISSUE, S_RD_CAP
    } state_t;

    state_t      state_q;
    logic [13:0] addr_q;
    logic [7:0]  rdbuf_q;
    logic [7:0]  latch_q;
    logic        toggle_q;
    logic [13:0] vram_addr_q;
    logic [7:0]  vram_din_q;
    logic        vram_we_q;
    logic        vram_re_q;

    // Only the register bits that drive something are kept.
    logic        r0_m3_q;
    logic [6:0]  r1_q;
    logic [3:0]  r2_q;
    logic [7:0]  r3_q;
    logic [2:0]  r4_q;
    logic [6:0]  r5_q;
    logic [2:0]  r6_q;
    logic [7:0]  r7_q;

    logic        f_q, s5_q, c_q;
    logic [4:0]  fifth_q;
    logic        f_d, s5_d, c_d;
    logic [4:0]  fifth_d;

    logic        idle;
    logic        stat_clr;
    logic [13:0] ptr_new;

    assign idle     = (state_q == S_IDLE);
    assign stat_clr = idle && bus.cpu_rd && bus.cpu_port;
    assign ptr_new  = {bus.cpu_din[5:0], latch_q};

    // Set events beat a coincident status-read clear.
    always_comb begin
        f_d     = (f_q & ~stat_clr) | frame_int;
        c_d     = (c_q & ~stat_clr) | sprite_collision;
        s5_d    = s5_q & ~stat_clr;
        fifth_d = fifth_q;
        if (!s5_q) begin
            fifth_d = sprite5;
            if (too_many_sprites)
                s5_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_q     <= 1'b0;
            s5_q    <= 1'b0;
            c_q     <= 1'b0;
            fifth_q <= 5'd0;
        end else begin
            f_q     <= f_d;
            s5_q    <= s5_d;
            c_q     <= c_d;
            fifth_q <= fifth_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 14'd0;
            rdbuf_q     <= 8'd0;
            latch_q     <= 8'd0;
            toggle_q    <= 1'b0;
            vram_addr_q <= 14'd0;
            vram_din_q  <= 8'd0;
            vram_we_q   <= 1'b0;
            vram_re_q   <= 1'b0;
            r0_m3_q     <= 1'b0;
            r1_q        <= 7'd0;
            r2_q        <= 4'd0;
            r3_q        <= 8'd0;
            r4_q        <= 3'd0;
            r5_q        <= 7'd0;
            r6_q        <= 3'd0;
            r7_q        <= 8'd0;
        end else begin
            vram_we_q <= 1'b0;
            vram_re_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.cpu_wr && !bus.cpu_port) begin
                        toggle_q    <= 1'b0;
                        vram_we_q   <= 1'b1;
                        vram_addr_q <= addr_q;
                        vram_din_q  <= bus.cpu_din;
`ifdef VDP_RDBUF_ON_WRITE_EN
                        rdbuf_q     <= bus.cpu_din;
`endif
                        state_q     <= S_WR;
                    end else if (bus.cpu_wr) begin
                        if (!toggle_q) begin
                            latch_q  <= bus.cpu_din;
                            toggle_q <= 1'b1;
                        end else begin
                            toggle_q <= 1'b0;
                            if (bus.cpu_din[7]) begin
                                case (bus.cpu_din[2:0])
                                    3'd0: r0_m3_q <= latch_q[1];
                                    3'd1: r1_q    <= latch_q[6:0];
                                    3'd2: r2_q    <= latch_q[3:0];
                                    3'd3: r3_q    <= latch_q;
                                    3'd4: r4_q    <= latch_q[2:0];
                                    3'd5: r5_q    <= latch_q[6:0];
                                    3'd6: r6_q    <= latch_q[2:0];
                                    3'd7: r7_q    <= latch_q;
                                endcase
                            end else begin
                                addr_q <= ptr_new;
                                // Bit 6 clear: pointer set for reading.
                                if (!bus.cpu_din[6]) begin
                                    vram_re_q   <= 1'b1;
                                    vram_addr_q <= ptr_new;
                                    state_q     <= S_RD_ISSUE;
                                end
                            end
                        end
                    end else if (bus.cpu_rd) begin
                        toggle_q <= 1'b0;
                        if (!bus.cpu_port) begin
                            vram_re_q   <= 1'b1;
                            vram_addr_q <= addr_q;
                            state_q     <= S_RD_ISSUE;
                        end
                    end
                end
                S_WR: begin
                    addr_q  <= addr_q + 14'd1;
                    state_q <= S_IDLE;
                end
                S_RD_ISSUE: begin
                    addr_q  <= addr_q + 14'd1;
                    state_q <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    rdbuf_q <= vram_dout;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign vram_addr = vram_addr_q;
    assign vram_din  = vram_din_q;
    assign vram_we   = vram_we_q;
    assign vram_re   = vram_re_q;

    assign bus.busy     = !idle;
    assign bus.cpu_dout = bus.cpu_port ? {f_q, s5_q, c_q, fifth_q}
                                       : rdbuf_q;

    // Text mode wins over graphics 2, which wins over multicolour.
    always_comb begin
        mode = 2'd1;
        priority case (1'b1)
            r1_q[4]: mode = 2'd0;
            r0_m3_q: mode = 2'd2;
            r1_q[3]: mode = 2'd3;
            default: mode = 2'd1;
        endcase
    end

    assign video_on         = r1_q[6];
    assign vert_retrace_int = r1_q[5];
    assign sprite_large     = r1_q[1];
    assign sprite_enlarged  = r1_q[0];
    assign text_color       = r7_q[7:4];
    assign back_color       = r7_q[3:0];

    assign name_table_addr           = {r2_q, 10'd0};
    assign sprite_attr_addr          = {r5_q, 7'd0};
    assign sprite_pattern_table_addr = {r6_q, 11'd0};

    // Graphics 2 uses only the top bit of R3/R4 (8K-aligned tables).
    assign color_table_addr = (mode == 2'd2) ? {r3_q[7], 13'd0}
                                             : {r3_q, 6'd0};
    assign font_addr        = (mode == 2'd2) ? {r4_q[2], 13'd0}
                                             : {r4_q, 11'd0};

    assign n_int = !(f_q && r1_q[5]);
endmodule
